// File: rtl/sig_meter_pkg.sv
// Shared definitions for the signal meter: FSM encoding, datapath widths and
// a saturating counter helper.
package sig_meter_pkg;

  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned COUNT_W  = 32;
  localparam int unsigned EDGE_W   = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [COUNT_W-1:0]  count_t;

  localparam sample_t SAMPLE_MAX = '1;
  localparam count_t  COUNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic count_t sat_inc(input count_t v);
    return (v == COUNT_MAX) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/sig_meter_if.sv
// Sample stream, configuration, control and result bundle of the signal meter.
//   master: drives adc_data/adc_valid/threshold/hyst/start, reads results
//   slave : the meter itself
interface sig_meter_if;
  import sig_meter_pkg::*;

  sample_t adc_data;
  logic    adc_valid;
  sample_t threshold;
  sample_t hyst;
  logic    start;

  logic    busy;
  logic    done;
  logic    timeout;
  count_t  period_sum;
  count_t  high_sum;
  sample_t vmax;
  sample_t vmin;

  modport master (
    output adc_data, adc_valid, threshold, hyst, start,
    input  busy, done, timeout, period_sum, high_sum, vmax, vmin
  );

  modport slave (
    input  adc_data, adc_valid, threshold, hyst, start,
    output busy, done, timeout, period_sum, high_sum, vmax, vmin
  );

endinterface

// File: rtl/sig_meter_cmp.sv
// Hysteresis comparator.
//   clk, reset_n        : clock, async active-low reset
//   adc_data, adc_valid : qualified sample stream
//   threshold, hyst     : centre level and hysteresis half-width
//   cmp_hi              : registered comparator state
//   rise, fall          : this qualified sample sets / clears cmp_hi (combinational)
module sig_meter_cmp
  import sig_meter_pkg::*;
(
  input  logic    clk,
  input  logic    reset_n,
  input  sample_t adc_data,
  input  logic    adc_valid,
  input  sample_t threshold,
  input  sample_t hyst,
  output logic    cmp_hi,
  output logic    rise,
  output logic    fall
);

  logic [SAMPLE_W:0] sum_c;
  logic [SAMPLE_W:0] diff_c;
  sample_t           thr_hi;
  sample_t           thr_lo;
  logic              set_c;
  logic              clr_c;

  // Levels in 13 bits; the top bit flags overflow (sum) or borrow (difference).
  always_comb begin
    sum_c  = {1'b0, threshold} + {1'b0, hyst};
    diff_c = {1'b0, threshold} - {1'b0, hyst};
    thr_hi = sum_c[SAMPLE_W]  ? SAMPLE_MAX : sum_c[SAMPLE_W-1:0];
    thr_lo = diff_c[SAMPLE_W] ? '0         : diff_c[SAMPLE_W-1:0];
    // thr_hi >= thr_lo always, so set and clear never coincide.
    set_c  = adc_valid && (adc_data >= thr_hi);
    clr_c  = adc_valid && (adc_data <  thr_lo);
    rise   = set_c && !cmp_hi;
    fall   = clr_c && cmp_hi;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmp_hi <= 1'b0;
    end else if (set_c) begin
      cmp_hi <= 1'b1;
    end else if (clr_c) begin
      cmp_hi <= 1'b0;
    end
  end

endmodule

// File: rtl/sig_meter.sv
// Signal meter: averages N_PER periods of a thresholded sample stream and
// reports period length, high time and min/max level.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : samples, threshold/hyst, start; busy/done/timeout and results
module sig_meter
  import sig_meter_pkg::*;
#(
  parameter int unsigned N_PER   = 16,
  parameter int unsigned TIMEOUT = 16777215
) (
  input logic        clk,
  input logic        reset_n,
  sig_meter_if.slave bus
);

  localparam count_t              TIMEOUT_C = COUNT_W'(TIMEOUT);
  localparam logic [EDGE_W-1:0]   LAST_EDGE = EDGE_W'(N_PER - 1);

  state_t            state;
  state_t            state_nx;
  logic              cmp_hi;
  logic              rise;
  logic              fall;
  logic              hi_now;
  logic              tmo_hit;
  logic              accept;
  logic              enter;
  logic              tally;
  logic              finish;
  logic              abort;
  count_t            tmo_cnt;
  count_t            period_cnt;
  count_t            high_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  sample_t           trk_max;
  sample_t           trk_min;

  sig_meter_cmp u_cmp (
    .clk       (clk),
    .reset_n   (reset_n),
    .adc_data  (bus.adc_data),
    .adc_valid (bus.adc_valid),
    .threshold (bus.threshold),
    .hyst      (bus.hyst),
    .cmp_hi    (cmp_hi),
    .rise      (rise),
    .fall      (fall)
  );

  // Comparator state as it will be after this sample.
  assign hi_now  = rise || (cmp_hi && !fall);
  assign tmo_hit = bus.adc_valid && ((tmo_cnt + COUNT_W'(1)) == TIMEOUT_C);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and datapath control; the terminating edge beats the timeout.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    enter    = 1'b0;
    tally    = 1'b0;
    finish   = 1'b0;
    abort    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nx = ST_ARM;
          accept   = 1'b1;
        end
      end
      ST_ARM: begin
        if (tmo_hit) begin
          state_nx = ST_DONE;
          abort    = 1'b1;
        end else if (rise) begin
          state_nx = ST_MEAS;
          enter    = 1'b1;
        end
      end
      ST_MEAS: begin
        if (rise && (edge_cnt == LAST_EDGE)) begin
          state_nx = ST_DONE;
          finish   = 1'b1;
        end else if (tmo_hit) begin
          state_nx = ST_DONE;
          abort    = 1'b1;
        end else if (bus.adc_valid) begin
          tally    = 1'b1;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Measurement accumulators; the entry edge sample is the first counted sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt    <= '0;
      period_cnt <= '0;
      high_cnt   <= '0;
      edge_cnt   <= '0;
      trk_max    <= '0;
      trk_min    <= '0;
    end else begin
      if (accept) begin
        tmo_cnt <= '0;
      end else if (((state == ST_ARM) || (state == ST_MEAS)) && bus.adc_valid) begin
        tmo_cnt <= sat_inc(tmo_cnt);
      end
      if (enter) begin
        // max(0, s) and min(4095, s) both reduce to the edge sample.
        edge_cnt   <= '0;
        period_cnt <= COUNT_W'(1);
        high_cnt   <= COUNT_W'(1);
        trk_max    <= bus.adc_data;
        trk_min    <= bus.adc_data;
      end else if (tally) begin
        period_cnt <= sat_inc(period_cnt);
        if (hi_now) high_cnt <= sat_inc(high_cnt);
        if (rise) edge_cnt <= edge_cnt + EDGE_W'(1);
        if (bus.adc_data > trk_max) trk_max <= bus.adc_data;
        if (bus.adc_data < trk_min) trk_min <= bus.adc_data;
      end
    end
  end

  // Registered status and results; results only change on entry to DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.timeout    <= 1'b0;
      bus.period_sum <= '0;
      bus.high_sum   <= '0;
      bus.vmax       <= '0;
      bus.vmin       <= '0;
    end else begin
      bus.done <= (state_nx == ST_DONE);
      bus.busy <= (state_nx == ST_ARM) || (state_nx == ST_MEAS);
      if (accept) begin
        bus.timeout <= 1'b0;
      end else if (abort) begin
        bus.timeout <= 1'b1;
      end
      if (finish) begin
        bus.period_sum <= period_cnt;
        bus.high_sum   <= high_cnt;
        bus.vmax       <= trk_max;
        bus.vmin       <= trk_min;
      end else if (abort) begin
        bus.period_sum <= '0;
        bus.high_sum   <= '0;
        bus.vmax       <= '0;
        bus.vmin       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sig_meter.sv
// Randomized bench for sig_meter. Each accepted measurement records the
// qualified samples seen since start; on done the expected results are
// derived by scanning that record for comparator edges.
module tb_sig_meter;
  import sig_meter_pkg::*;

  localparam int unsigned N_PER = 16;
  localparam int unsigned TMO   = 5000;

  logic clk = 1'b0;
  logic reset_n;

  sig_meter_if bus ();

  sig_meter #(.N_PER(N_PER), .TIMEOUT(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // stimulus state
  int wave_kind;   // 0 square 3000/1000, 1 constant 2048, 2 parametric square
  int wave_pos;
  int noise_amp;
  int valid_mode;  // 0 always, 1 every 2nd cycle, 2 random
  int valid_pct;
  int cyc_cnt;
  int r_hi, r_lo, r_hh, r_hl;
  int cfg_thr, cfg_hy;

  // reference model state
  bit cmp_m;
  bit active;
  bit in_done_cyc;
  int q_s[$];
  bit q_hi[$];
  bit q_rise[$];
  int n_accept;
  int n_done;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int gen_sample();
    int b;
    int p;
    case (wave_kind)
      0: b = ((wave_pos % 200) < 100) ? 3000 : 1000;
      1: b = 2048;
      default: begin
        p = r_hh + r_hl;
        b = ((wave_pos % p) < r_hh) ? r_hi : r_lo;
      end
    endcase
    if (noise_amp > 0) b = b + int'($urandom_range(0, 2 * noise_amp)) - noise_amp;
    if (b < 0) b = 0;
    if (b > 4095) b = 4095;
    return b;
  endfunction

  task automatic set_cfg(input int thr, input int hy);
    cfg_thr       = thr;
    cfg_hy        = hy;
    bus.threshold = 12'(thr);
    bus.hyst      = 12'(hy);
  endtask

  // Expected outcome of the recorded measurement, compared with the DUT on done.
  task automatic evaluate();
    int  r0 = -1;
    int  rises = 0;
    int  term = -1;
    bit  tmo = 1'b0;
    longint per = 0;
    longint hig = 0;
    int  mx = 0;
    int  mn = 0;
    for (int i = 0; i < q_s.size(); i++) begin
      if (r0 < 0) begin
        if (i == int'(TMO) - 1) begin term = i; tmo = 1'b1; break; end
        if (q_rise[i]) r0 = i;
      end else begin
        if (q_rise[i]) begin
          rises++;
          if (rises == int'(N_PER)) begin term = i; break; end
        end
        if (i == int'(TMO) - 1) begin term = i; tmo = 1'b1; break; end
      end
    end
    if (!tmo && term >= 0) begin
      per = longint'(term - r0);
      mx  = 0;
      mn  = 4095;
      for (int j = r0; j < term; j++) begin
        if (q_hi[j]) hig++;
        if (q_s[j] > mx) mx = q_s[j];
        if (q_s[j] < mn) mn = q_s[j];
      end
    end
    check_eq("done_latency", 64'(q_s.size()), 64'(term + 1));
    check_eq("timeout", 64'(bus.timeout), 64'(tmo));
    check_eq("period_sum", 64'(bus.period_sum), 64'(per));
    check_eq("high_sum", 64'(bus.high_sum), 64'(hig));
    check_eq("vmax", 64'(bus.vmax), 64'(mx));
    check_eq("vmin", 64'(bus.vmin), 64'(mn));
    check_eq("busy_at_done", 64'(bus.busy), 64'(0));
  endtask

  // One clock: drive inputs, let the DUT sample them, mirror in the model, check.
  task automatic cycle(input bit st);
    bit v;
    bit hi_after;
    bit acc;
    int s;
    int th_hi;
    int th_lo;
    acc = 1'b0;
    case (valid_mode)
      0:       v = 1'b1;
      1:       v = cyc_cnt[0];
      default: v = (int'($urandom_range(0, 99)) < valid_pct);
    endcase
    cyc_cnt++;
    if (v) begin
      s = gen_sample();
      wave_pos++;
    end else begin
      s = int'($urandom_range(0, 4095));
    end
    bus.adc_valid = v;
    bus.adc_data  = 12'(s);
    bus.start     = st;
    @(posedge clk);
    if (reset_n) begin
      if (v) begin
        th_hi = (cfg_thr + cfg_hy > 4095) ? 4095 : cfg_thr + cfg_hy;
        th_lo = (cfg_thr - cfg_hy < 0) ? 0 : cfg_thr - cfg_hy;
        if (s >= th_hi) hi_after = 1'b1;
        else if (s < th_lo) hi_after = 1'b0;
        else hi_after = cmp_m;
        if (active) begin
          q_s.push_back(s);
          q_hi.push_back(hi_after);
          q_rise.push_back(hi_after && !cmp_m);
        end
        cmp_m = hi_after;
      end
      if (st && !active && !in_done_cyc) begin
        active = 1'b1;
        acc    = 1'b1;
        q_s.delete();
        q_hi.delete();
        q_rise.delete();
        n_accept++;
      end
    end
    in_done_cyc = 1'b0;
    #1;
    bus.start = 1'b0;
    if (acc) check_eq("busy_after_start", 64'(bus.busy), 64'(1));
    if (!active) begin
      check_eq("done_while_idle", 64'(bus.done), 64'(0));
    end else if (bus.done) begin
      n_done++;
      evaluate();
      active      = 1'b0;
      in_done_cyc = 1'b1;
    end
  endtask

  task automatic run_meas(input string tag, input int pre, input int budget);
    int d0;
    int k;
    d0 = n_done;
    k  = 0;
    repeat (pre) cycle(1'b0);
    cycle(1'b1);
    while (n_done == d0 && k < budget) begin
      cycle(1'b0);
      k++;
    end
    check_eq({tag, "_done_seen"}, 64'(n_done), 64'(d0 + 1));
    repeat (3) cycle(1'b0);
  endtask

  task automatic check_fixed(input string tag, input int per, input int hig,
                             input int mx, input int mn, input int tmo);
    check_eq({tag, "_period_sum"}, 64'(bus.period_sum), 64'(per));
    check_eq({tag, "_high_sum"}, 64'(bus.high_sum), 64'(hig));
    check_eq({tag, "_vmax"}, 64'(bus.vmax), 64'(mx));
    check_eq({tag, "_vmin"}, 64'(bus.vmin), 64'(mn));
    check_eq({tag, "_timeout"}, 64'(bus.timeout), 64'(tmo));
  endtask

  initial begin
    int d0;
    int k;
    reset_n       = 1'b0;
    bus.adc_data  = '0;
    bus.adc_valid = 1'b0;
    bus.start     = 1'b0;
    set_cfg(2048, 64);
    wave_kind = 0; wave_pos = 0; noise_amp = 0; valid_mode = 0; valid_pct = 100;
    cyc_cnt = 0; r_hi = 0; r_lo = 0; r_hh = 1; r_hl = 1;
    cmp_m = 1'b0; active = 1'b0; in_done_cyc = 1'b0; n_accept = 0; n_done = 0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(bus.busy), 64'(0));
    check_eq("rst_done", 64'(bus.done), 64'(0));
    check_fixed("rst", 0, 0, 0, 0, 0);
    reset_n = 1'b1;

    // clean square wave, continuous valid
    run_meas("sq", 10, 6000);
    check_fixed("sq", 3200, 1600, 3000, 1000, 0);

    // same stream, valid every second cycle
    valid_mode = 1;
    run_meas("sq_half", 7, 12000);
    check_fixed("sq_half", 3200, 1600, 3000, 1000, 0);

    // noisy square wave: noise stays well inside the hysteresis band margins
    valid_mode = 0;
    noise_amp  = 50;
    run_meas("noise", 33, 6000);
    check_eq("noise_period_sum", 64'(bus.period_sum), 64'(3200));
    check_eq("noise_high_sum", 64'(bus.high_sum), 64'(1600));

    // constant input never crosses: abort after TMO qualified samples
    noise_amp = 0;
    wave_kind = 1;
    run_meas("tmo", 5, 6000);
    check_fixed("tmo", 0, 0, 0, 0, 1);

    // reset mid-measurement, then a fresh measurement
    wave_kind = 0;
    repeat (5) cycle(1'b0);
    cycle(1'b1);
    repeat (800) cycle(1'b0);
    check_eq("busy_mid_meas", 64'(bus.busy), 64'(1));
    reset_n = 1'b0;
    #1;
    check_eq("midrst_busy", 64'(bus.busy), 64'(0));
    check_fixed("midrst", 0, 0, 0, 0, 0);
    active = 1'b0; cmp_m = 1'b0; in_done_cyc = 1'b0;
    n_accept = n_done;
    repeat (3) cycle(1'b0);
    reset_n = 1'b1;
    repeat (20) cycle(1'b0);
    run_meas("after_rst", 3, 6000);
    check_fixed("after_rst", 3200, 1600, 3000, 1000, 0);

    // starts while busy and in the done cycle are ignored
    d0 = n_done;
    k  = 0;
    cycle(1'b1);
    while (n_done == d0 && k < 6000) begin
      cycle(($urandom_range(0, 7) == 0));
      k++;
    end
    check_eq("busy_start_one_done", 64'(n_done), 64'(d0 + 1));
    cycle(1'b1);
    check_eq("done_cycle_start_busy", 64'(bus.busy), 64'(0));
    cycle(1'b0);
    check_eq("done_cycle_start_idle", 64'(bus.busy), 64'(0));
    check_eq("accepts_vs_dones", 64'(n_done), 64'(n_accept));
    repeat (3) cycle(1'b0);

    // thr_hi saturates at 4095: only 4095 sets, 3000 clears
    set_cfg(4000, 200);
    wave_kind = 2; r_hi = 4095; r_lo = 3000; r_hh = 50; r_hl = 50;
    run_meas("sat_hi", 10, 6000);
    check_fixed("sat_hi", 1600, 800, 4095, 3000, 0);

    // thr_lo saturates at 0: comparator can never clear, so the run aborts
    set_cfg(50, 200);
    r_hi = 3000; r_lo = 0;
    run_meas("sat_lo", 10, 6000);
    check_fixed("sat_lo", 0, 0, 0, 0, 1);

    // randomized waveforms, thresholds and valid patterns
    for (int t = 0; t < 5; t++) begin
      set_cfg(int'($urandom_range(1600, 2500)), int'($urandom_range(0, 100)));
      wave_kind  = 2;
      r_hi       = int'($urandom_range(2700, 4095));
      r_lo       = int'($urandom_range(0, 1400));
      r_hh       = int'($urandom_range(5, 40));
      r_hl       = int'($urandom_range(5, 40));
      noise_amp  = int'($urandom_range(0, 80));
      valid_mode = 2;
      valid_pct  = int'($urandom_range(50, 100));
      run_meas("rnd", int'($urandom_range(1, 50)), 12000);
    end
    check_eq("total_accepts_vs_dones", 64'(n_done), 64'(n_accept));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
